// File: rtl/morph_window_buffer_if.sv
// rtl/morph_window_buffer_if.sv - pixel stream in / window stream out bundle for the morphology window buffer
interface morph_window_buffer_if #(
    parameter int WindowBits = 9
);
    logic                  in_valid;
    logic                  in_sof;
    logic                  in_pixel;
    logic                  out_valid;
    logic                  out_last;
    logic [WindowBits-1:0] out_window;

    // Pixel source / window consumer side
    modport master (
        output in_valid,
        output in_sof,
        output in_pixel,
        input  out_valid,
        input  out_last,
        input  out_window
    );

    // Window buffer side
    modport slave (
        input  in_valid,
        input  in_sof,
        input  in_pixel,
        output out_valid,
        output out_last,
        output out_window
    );
endinterface

// File: rtl/morph_window_buffer.sv
// rtl/morph_window_buffer.sv - binary line buffer and Width x Height window generator for erode/dilate nodes
module morph_window_buffer #(
    parameter int Width       = 3,
    parameter int Height      = 3,
    parameter int ImageWidth  = 640,
    parameter int ImageHeight = 480
) (
    input  logic                clk,
    input  logic                rst,
    morph_window_buffer_if.slave bus
);
    localparam int ColBits = $clog2(ImageWidth);
    localparam int RowBits = $clog2(ImageHeight);
    localparam int WinBits = Width * Height;

    localparam logic [ColBits-1:0] ColLast       = ColBits'(ImageWidth - 1);
    localparam logic [RowBits-1:0] RowLast       = RowBits'(ImageHeight - 1);
    localparam logic [ColBits-1:0] ColFirstValid = ColBits'(Width - 1);
    localparam logic [RowBits-1:0] RowFirstValid = RowBits'(Height - 1);

    logic [ColBits-1:0]    col_q;
    logic [RowBits-1:0]    row_q;
    logic [ColBits-1:0]    pos_col;
    logic [RowBits-1:0]    pos_row;
    logic                  accept;
    logic                  pos_valid;
    logic                  pos_last;
    logic [Height-1:0]     new_col;
    logic [ImageWidth-1:0] linebuf [Height-1];
    logic [WinBits-1:0]    win_q;
    logic                  valid_q;
    logic                  last_q;

    // Position of the pixel being accepted; in_sof forces (0,0) regardless of the counters
    always_comb begin
        accept    = bus.in_valid;
        pos_col   = bus.in_sof ? '0 : col_q;
        pos_row   = bus.in_sof ? '0 : row_q;
        pos_valid = (pos_row >= RowFirstValid) && (pos_col >= ColFirstValid);
        pos_last  = pos_valid && (pos_row == RowLast) && (pos_col == ColLast);
    end

    // Incoming window column: older lines from the buffers (pre-write values), newest line from the stream
    always_comb begin
        new_col = '0;
        for (int k = 0; k < Height - 1; k++) begin
            new_col[k] = linebuf[k][pos_col];
        end
        new_col[Height-1] = bus.in_pixel;
    end

    // Raster counters: column wraps into the next row, bottom-right wraps to the frame origin
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (pos_col == ColLast) begin
                col_q <= '0;
                row_q <= (pos_row == RowLast) ? '0 : pos_row + 1'b1;
            end else begin
                col_q <= pos_col + 1'b1;
                row_q <= pos_row;
            end
        end
    end

    // Line buffers shift one line older at the current column; contents are hidden by valid gating so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < Height - 2; k++) begin
                linebuf[k][pos_col] <= linebuf[k+1][pos_col];
            end
            linebuf[Height-2][pos_col] <= bus.in_pixel;
        end
    end

    // Window rows shift toward column 0 and take the new column at column Width-1
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else if (accept) begin
            for (int l = 0; l < Height; l++) begin
                win_q[l*Width +: Width] <= {new_col[l], win_q[l*Width+1 +: Width-1]};
            end
        end
    end

    // Output qualifiers: one-cycle pulse per in-image window, last marks the bottom-right window
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= accept && pos_valid;
            last_q  <= accept && pos_last;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_last   = last_q;
    assign bus.out_window = win_q;
endmodule

// File: tb/tb_morph_window_buffer.sv
// tb/tb_morph_window_buffer.sv - randomized and directed bench for morph_window_buffer against an image-array model
module tb_morph_window_buffer;
    localparam int W  = 3;
    localparam int H  = 3;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int WB = W * H;

    logic clk = 1'b0;
    logic rst;

    morph_window_buffer_if #(.WindowBits(WB)) bus ();

    morph_window_buffer #(
        .Width      (W),
        .Height     (H),
        .ImageWidth (IW),
        .ImageHeight(IH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit img [IH][IW];
    int m_row;
    int m_col;
    logic [WB:0] seen [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WB-1:0] model_window(input int r, input int c);
        logic [WB-1:0] w;
        w = '0;
        for (int l = 0; l < H; l++) begin
            for (int k = 0; k < W; k++) begin
                w[l*W+k] = img[r-(H-1)+l][c-(W-1)+k];
            end
        end
        return w;
    endfunction

    task automatic push_pixel(input bit sof, input bit pix);
        int  r;
        int  c;
        int  idx;
        bit  ev;
        bit  el;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = pix;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        r = m_row;
        c = m_col;
        img[r][c] = pix;
        ev = (r >= H - 1) && (c >= W - 1);
        el = ev && (r == IH - 1) && (c == IW - 1);
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
        check("out_last", {31'd0, bus.out_last}, {31'd0, el});
        if (ev) check("out_window", 32'(bus.out_window), 32'(model_window(r, c)));
        if (bus.out_valid) seen.push_back({bus.out_last, bus.out_window});
        idx   = (r * IW + c + 1) % (IW * IH);
        m_row = idx / IW;
        m_col = idx % IW;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
            check("idle_last", {31'd0, bus.out_last}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_window", 32'(bus.out_window), 32'd0);
        rst   = 1'b0;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic frame_t1(input bit with_sof, input int gap);
        for (int i = 0; i < IW * IH; i++) begin
            push_pixel(with_sof && (i == 0), i == 5);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic check_t1_seq(input string tag);
        logic [WB-1:0] exp_win [4];
        int n;
        exp_win[0] = 9'h010;
        exp_win[1] = 9'h008;
        exp_win[2] = 9'h002;
        exp_win[3] = 9'h001;
        check({tag, "_count"}, 32'(seen.size()), 32'd4);
        n = (seen.size() < 4) ? seen.size() : 4;
        for (int i = 0; i < n; i++) begin
            check({tag, "_win"}, 32'(seen[i][WB-1:0]), 32'(exp_win[i]));
            check({tag, "_last"}, {31'd0, seen[i][WB]}, {31'd0, i == 3});
        end
        seen.delete();
    endtask

    task automatic check_const_seq(input string tag, input int count, input logic [WB-1:0] first, input logic [WB-1:0] second);
        int n;
        check({tag, "_count"}, 32'(seen.size()), 32'(count));
        n = (seen.size() < count) ? seen.size() : count;
        for (int i = 0; i < n; i++) begin
            check({tag, "_win"}, 32'(seen[i][WB-1:0]), 32'((i < 4) ? first : second));
            check({tag, "_last"}, {31'd0, seen[i][WB]}, {31'd0, (i % 4) == 3});
        end
        seen.delete();
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = 1'b0;
        m_row        = 0;
        m_col        = 0;

        do_reset();
        idle(2);

        // single hot pixel at (1,1)
        frame_t1(1'b1, 0);
        check_t1_seq("t1");

        // all-ones frame
        for (int i = 0; i < IW * IH; i++) push_pixel(i == 0, 1'b1);
        check_const_seq("t2", 4, 9'h1FF, 9'h1FF);

        // gaps between pixels
        frame_t1(1'b1, 3);
        check_t1_seq("t3");

        // back-to-back ones then zeros frames
        for (int i = 0; i < IW * IH; i++) push_pixel(i == 0, 1'b1);
        for (int i = 0; i < IW * IH; i++) push_pixel(i == 0, 1'b0);
        check_const_seq("t4", 8, 9'h1FF, 9'h000);

        // reset mid-frame, then a frame without in_sof
        for (int i = 0; i < 7; i++) push_pixel(i == 0, 1'($urandom_range(0, 1)));
        seen.delete();
        do_reset();
        frame_t1(1'b0, 0);
        check_t1_seq("t5");

        // truncated frame by in_sof on pixel 9
        for (int i = 0; i < 8; i++) push_pixel(i == 0, 1'($urandom_range(0, 1)));
        check("t6_trunc_count", 32'(seen.size()), 32'd0);
        frame_t1(1'b1, 0);
        check_t1_seq("t6");

        // random frames with random gaps and occasional mid-frame in_sof
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < IW * IH + 4; i++) begin
                push_pixel((i == 0) || ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        seen.delete();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/morph_window_buffer.md
Name: morph_window_buffer

Overview:
Streaming line-buffer and window generator for the binary morphology path. It accepts one binary pixel per valid cycle in raster order and builds the Width x Height neighbourhood around each pixel. The window is presented on a flat bus whose bit layout matches the morphology nodes' D input. It sits directly upstream of the erode/dilate nodes and feeds their D port, with one registered stage between the pixel stream and the node array.

Parameters:
Width, 3, window columns (>=2)
Height, 3, window rows (>=2)
ImageWidth, 640, pixels per image line (>=Width)
ImageHeight, 480, lines per frame (>=Height)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_pixel is accepted this cycle
in_sof  input  1  qualifies with in_valid: this pixel is row 0, col 0 of a new frame
in_pixel  input  1  binary pixel
out_valid  output  1  out_window holds a complete in-image window
out_last  output  1  with out_valid: last window of the frame (bottom-right)
out_window  output  Width*Height  window bits; bit l*Width+c = row l (0=oldest/top), column c (0=oldest/left)

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_last=0, out_window=0.
  - Column counter col=0, row counter row=0.
  - Window column shift registers cleared.
  - Line-buffer contents need not be cleared; they are never exposed before being rewritten, because of valid gating.
  - Reset mid-frame abandons the frame. The next accepted pixel is treated as (0,0) whether or not in_sof is asserted.
- Accepted pixel: in_valid=1 at a rising edge. Cycles with in_valid=0 change nothing except out_valid, out_last <= 0. There is no backpressure; the downstream is always ready.
- Position of each accepted pixel:
  - if in_sof=1, the pixel is (0,0);
  - otherwise it is the current (row, col).
  - After acceptance, col increments. At ImageWidth-1, col wraps to 0 and row increments. At (ImageHeight-1, ImageWidth-1), both counters wrap to 0.
  - in_sof mid-frame truncates the frame: counters restart and there is no out_last for the truncated frame.
- Line buffers:
  - Height-1 buffers of ImageWidth bits, addressed by col.
  - On acceptance at column col: new_col[Height-1] = in_pixel, and new_col[k] = linebuf[k][col] for k = 0..Height-2 (linebuf[0] = oldest line).
  - Then linebuf[k][col] <= linebuf[k+1][col] and linebuf[Height-2][col] <= in_pixel, so each buffer holds a line one row older than the next.
  - Reads use the value before that cycle's write.
- Window register: on acceptance, every row l shifts left by one column (c <= c+1), and column Width-1 of row l <= new_col[l].
- Output register, one cycle latency:
  - On the edge after acceptance, out_window = updated window.
  - out_valid = 1 iff row >= Height-1 and col >= Width-1, where (row, col) is the position of the accepted pixel.
  - out_last = out_valid AND position == (ImageHeight-1, ImageWidth-1).
- The window is centred at position (row-(Height-1)/2, col-(Width-1)/2). No border padding: border pixels produce no window, giving (ImageHeight-Height+1)*(ImageWidth-Width+1) windows per frame.
- At a line wrap, the left columns of the window contain stale data from the previous line. The col >= Width-1 gating guarantees these are never output as valid.
- out_window is held while out_valid=0; downstream must ignore it.

Test Plan:
Unless stated, parameters are 3x3 window, ImageWidth=4, ImageHeight=4.
1. Reset, then a 16-pixel frame (in_sof on the first pixel) with pixel 1 only at raster index 5 (row 1, col 1), all others 0 -> exactly 4 out_valid pulses, in order: out_window=9'h010, 9'h008, 9'h002, 9'h001; out_last=1 only on the 4th; out_valid=0 for the first 10 accepted pixels.
2. All-ones frame -> 4 windows, each 9'h1FF; windows of pixels accepted at col 0/1 are never valid.
3. Same frame as test 1 with in_valid dropped for 3 cycles between every pixel -> identical 4 windows and order; out_valid stays a single-cycle pulse.
4. Two back-to-back frames, first all ones, second all zeros, no idle cycles between them -> 4x 9'h1FF, then 4x 9'h000; no window mixes the two frames (in_sof restarts the counters, valid gating hides stale lines).
5. Assert rst for 1 cycle after 7 pixels of a frame, then a full test-1 frame without in_sof -> out_valid=0 during and right after reset; the test-1 sequence is reproduced exactly.
6. Assert in_sof on pixel 9 of a frame, then 16 pixels of the test-1 pattern -> no out_last for the truncated frame; the new frame yields the test-1 results.
